core_job_initiator: RTL and testbench
=====================================

Name: core_job_initiator

Overview:
- Host-side initiator for the 8-operand compute core (start/done handshake, i1..i8 operands, 32-bit result).
- Accepts operands over a simple register-write port and drives them steady on o1..o8 to the core.
- Issues a one-cycle core_start, waits for core_done, captures core_result, then offers it downstream on a valid/ready port.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; used only with TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- wr_en  input  1  operand write strobe.
- wr_addr  input  3  operand index: 0 selects o1 … 7 selects o8.
- wr_data  input  WIDTH  operand value.
- go  input  1  launch request.
- busy  output  1  high whenever state is not IDLE.
- o1..o8  output  WIDTH each  operands to core i1..i8.
- core_start  output  1  start pulse to core.
- core_done  input  1  core completion.
- core_result  input  WIDTH  core result.
- res_valid  output  1  captured result available.
- res_ready  input  1  downstream accepts result.
- res_data  output  WIDTH  captured result.
- job_count  output  8  completed-and-accepted jobs.
- timeout_err  output  1  sticky watchdog flag.

Behaviour:
- Reset, taken on a clk edge with rst=0:
  - state=IDLE.
  - o1..o8=0, res_data=0, job_count=0.
  - core_start=0, res_valid=0, timeout_err=0.
  - A reset mid-job aborts the job immediately; any late core_done is ignored.
- All outputs are registered; busy is decoded from state.
- Operand writes:
  - Accepted only in IDLE; o[wr_addr] <= wr_data.
  - Writes in any other state are ignored, so operands stay stable for the whole job.
- States:
  - IDLE:
    - go=1 moves to LAUNCH.
    - If wr_en and go arrive in the same cycle, the write lands first and the launched job uses the new value.
  - LAUNCH:
    - core_start=1 for exactly this one cycle.
    - Next state is WAIT; core_done is ignored here.
  - WAIT:
    - core_start=0.
    - On core_done=1: res_data <= core_result, res_valid <= 1, go to HOLD.
  - HOLD:
    - res_valid stays 1 and res_data is held until res_ready=1.
    - On the valid&&ready edge: res_valid <= 0, job_count <= job_count+1 (wraps 255 to 0), go to IDLE.
    - If res_ready is already high on entry to HOLD, the transfer completes on the first HOLD cycle.
- Latency: go in cycle N gives core_start in cycle N+1; done seen in cycle M gives res_valid in cycle M+1.
- go outside IDLE is ignored (no queuing).
- A core_done that stays high in IDLE or LAUNCH has no effect.

Optional Feature:
- Macro: CORE_JOB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without core_done: res_data <= all ones, res_valid <= 1, timeout_err <= 1, go to HOLD.
  - If core_done and the limit coincide, done wins and no error is flagged.
  - timeout_err clears on the next accepted go or on reset.
- Not defined: no counter exists, WAIT lasts indefinitely, and timeout_err is tied to 0.

Test Plan:
- Normal job:
  - Stimulus: after reset, write 2,2,2,2,3,1,3,2 to addresses 0..7, then pulse go; stub core returns the operand sum 5 cycles after start; res_ready held at 1.
  - Response: core_start high exactly 1 cycle (one cycle after go); o1..o8 match the writes; res_data=17; res_valid high 1 cycle; job_count=1; busy returns to 0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles after done.
  - Response: res_valid stays 1 and res_data stays 17 throughout; writes and go attempted during this window are ignored; completes on the edge where res_ready is raised.
- Same-cycle write and go:
  - Stimulus: in IDLE, wr_en with addr 4 and data 9 together with go.
  - Response: o5=9 at core_start; stub core returns sum 23.
- Reset mid-job:
  - Stimulus: assert rst=0 in WAIT, then assert core_done after rst is released.
  - Response: all outputs return to reset values; res_valid stays 0; job_count=0.
- Wrap:
  - Stimulus: run 256 jobs.
  - Response: job_count=0.
- Timeout (CORE_JOB_TIMEOUT_EN, TIMEOUT_CYCLES=20):
  - Stimulus: stub core never asserts done.
  - Response: res_valid rises 21 cycles after core_start; res_data=32'hFFFFFFFF; timeout_err=1, which clears on the next go.

Source files
------------

// File: rtl/core_job_initiator.sv
// Host-side initiator for the 8-operand compute core: loads operands, fires core_start,
// captures core_result, and offers it on a valid/ready port. Optional watchdog: CORE_JOB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | accepting operand writes, waiting for go
// LAUNCH | core_start high for this single cycle
// WAIT   | operands frozen, waiting for core_done (or watchdog expiry)
// HOLD   | res_valid high with res_data held until res_ready
module core_job_initiator #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             go,
  output logic             busy,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [WIDTH-1:0] o8,
  output logic             core_start,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [7:0]       job_count,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ops [8];
  logic             wd_hit;

  logic             start_nx, valid_nx, terr_nx;
  logic [WIDTH-1:0] data_nx;
  logic [7:0]       job_nx;

`ifdef CORE_JOB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;

  // Fires on the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
  assign wd_hit = (state == WAIT) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst)                 wd_cnt <= '0;
    else if (state == LAUNCH) wd_cnt <= '0;
    else if (state == WAIT)   wd_cnt <= wd_cnt + 16'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign wd_hit         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (core_done || wd_hit) state_nx = HOLD;
      HOLD:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_nx = (state == IDLE) && go;
    valid_nx = res_valid;
    data_nx  = res_data;
    job_nx   = job_count;
    terr_nx  = timeout_err;
    case (state)
      IDLE: if (go) terr_nx = 1'b0;
      WAIT: begin
        // A done that coincides with the watchdog limit wins.
        if (core_done) begin
          valid_nx = 1'b1;
          data_nx  = core_result;
        end else if (wd_hit) begin
          valid_nx = 1'b1;
          data_nx  = '1;
          terr_nx  = 1'b1;
        end
      end
      HOLD: if (res_ready) begin
        valid_nx = 1'b0;
        job_nx   = job_count + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) ops[i] <= '0;
      core_start  <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      job_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == IDLE) && wr_en) ops[wr_addr] <= wr_data;
      core_start  <= start_nx;
      res_valid   <= valid_nx;
      res_data    <= data_nx;
      job_count   <= job_nx;
      timeout_err <= terr_nx;
    end
  end

  assign busy = (state != IDLE);
  assign o1   = ops[0];
  assign o2   = ops[1];
  assign o3   = ops[2];
  assign o4   = ops[3];
  assign o5   = ops[4];
  assign o6   = ops[5];
  assign o7   = ops[6];
  assign o8   = ops[7];

endmodule

// File: tb/tb_core_job_initiator.sv
// Directed bench for core_job_initiator: a vector table for the first job, then
// hand-written sequences for backpressure, write+go, done corner cases, reset and wrap.
module tb_core_job_initiator;

`ifdef CORE_JOB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        go = 1'b0;
  logic        res_ready = 1'b1;
  logic        man_done = 1'b0;
  logic        stub_en = 1'b1;
  logic        stub_done = 1'b0;
  logic [3:0]  stub_cnt = '0;

  logic        busy, core_start, core_done, res_valid, timeout_err;
  logic [31:0] o1, o2, o3, o4, o5, o6, o7, o8, core_result, res_data;
  logic [7:0]  job_count;
  logic [31:0] ov [8];

  int n_vec = 0;
  int n_err = 0;

  core_job_initiator #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .busy(busy),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7), .o8(o8),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .job_count(job_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign ov[0] = o1; assign ov[1] = o2; assign ov[2] = o3; assign ov[3] = o4;
  assign ov[4] = o5; assign ov[5] = o6; assign ov[6] = o7; assign ov[7] = o8;

  // Stub core: result is the operand sum, done pulses 5 cycles after core_start.
  assign core_result = o1 + o2 + o3 + o4 + o5 + o6 + o7 + o8;
  assign core_done   = stub_done | man_done;

  always @(posedge clk) begin
    if (core_start && stub_en) stub_cnt <= 4'd5;
    else if (stub_cnt != 0)    stub_cnt <= stub_cnt - 4'd1;
    stub_done <= (stub_cnt == 4'd2);
  end

  typedef struct {
    logic        wr_en;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        go;
    logic        e_busy;
    logic        e_start;
    logic        e_valid;
    logic [31:0] e_data;
    logic [7:0]  e_job;
  } vec_t;

  vec_t vt [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int max, input string nm);
    int n;
    n = 0;
    while (!res_valid && n < max) begin
      step();
      n++;
    end
    if (!res_valid) check(nm, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n;
    n = 0;
    while (busy && n < max) begin
      step();
      n++;
    end
    if (busy) check(nm, 64'd1, 64'd0);
  endtask

  initial begin
    logic [31:0] w [8];
    logic        seen;
    int          n;
    w[0] = 2; w[1] = 2; w[2] = 2; w[3] = 2; w[4] = 3; w[5] = 1; w[6] = 3; w[7] = 2;

    for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 3'(i), w[i], 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0};
    vt[8]  = '{1'b0, 3'd0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  8'd0};
    vt[9]  = '{1'b0, 3'd0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  8'd0};
    vt[10] = '{1'b0, 3'd0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  8'd0};
    vt[11] = '{1'b1, 3'd0, 32'd99, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  8'd0};
    vt[12] = '{1'b0, 3'd0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  8'd0};
    vt[13] = '{1'b0, 3'd0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  8'd0};
    vt[14] = '{1'b0, 3'd0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 32'd17, 8'd0};
    vt[15] = '{1'b0, 3'd0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd17, 8'd1};

    step(); step();
    check("reset_state", {busy, core_start, res_valid, timeout_err, res_data, job_count}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wr_en = vt[i].wr_en; wr_addr = vt[i].addr; wr_data = vt[i].data; go = vt[i].go;
      step();
      check($sformatf("vec%0d", i), {busy, core_start, res_valid, res_data, job_count},
            {vt[i].e_busy, vt[i].e_start, vt[i].e_valid, vt[i].e_data, vt[i].e_job});
    end
    wr_en = 1'b0; go = 1'b0;
    for (int i = 0; i < 8; i++) check($sformatf("operand%0d", i + 1), ov[i], w[i]);

    // Backpressure: result held for 10 cycles, writes and go ignored meanwhile.
    res_ready = 1'b0;
    go = 1'b1; step(); go = 1'b0;
    wait_valid(20, "bp_valid_timeout");
    check("bp_first", {res_valid, res_data}, {1'b1, 32'd17});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd50; go = 1'b1;
      step();
      if (!(res_valid && busy && res_data == 32'd17)) seen = 1'b1;
    end
    wr_en = 1'b0; go = 1'b0;
    check("bp_hold", seen, 1'b0);
    res_ready = 1'b1;
    step();
    check("bp_release", {res_valid, busy, job_count}, {1'b0, 1'b0, 8'd2});
    check("bp_operand_kept", o1, 32'd2);

    // Same-cycle write and go: o5 takes 9, sum becomes 23.
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'd9; go = 1'b1;
    step();
    wr_en = 1'b0; go = 1'b0;
    check("wg_start", {core_start, o5}, {1'b1, 32'd9});
    wait_valid(20, "wg_valid_timeout");
    check("wg_result", res_data, 32'd23);
    step();
    check("wg_count", job_count, 8'd3);

    // core_done held in IDLE has no effect; in LAUNCH it is ignored.
    man_done = 1'b1;
    step(); step(); step();
    check("done_in_idle", {busy, res_valid}, 2'b00);
    go = 1'b1; step(); go = 1'b0;
    check("done_launch", {core_start, res_valid}, 2'b10);
    step();
    check("done_wait_entry", {busy, res_valid}, 2'b10);
    step();
    check("done_wait_capture", {res_valid, res_data}, {1'b1, 32'd23});
    man_done = 1'b0;
    step();
    check("done_count", job_count, 8'd4);
    step(); step(); step(); step(); step(); step();

`ifdef CORE_JOB_TIMEOUT_EN
    stub_en = 1'b0;
    go = 1'b1; step(); go = 1'b0;
    check("to_start", core_start, 1'b1);
    n = 0;
    while (!res_valid && n < 100) begin
      step();
      n++;
    end
    check("to_latency", n, 21);
    check("to_result", {timeout_err, res_data}, {1'b1, 32'hFFFFFFFF});
    step();
    check("to_sticky", {busy, timeout_err, job_count}, {1'b0, 1'b1, 8'd5});
    stub_en = 1'b1;
    go = 1'b1; step(); go = 1'b0;
    check("to_clear", timeout_err, 1'b0);
    wait_idle(30, "to_idle_timeout");
`else
    stub_en = 1'b0;
    go = 1'b1; step(); go = 1'b0;
    for (int i = 0; i < 40; i++) step();
    check("no_wd_wait", {busy, res_valid, timeout_err}, 3'b100);
    man_done = 1'b1; step(); man_done = 1'b0;
    check("no_wd_done", res_valid, 1'b1);
    step();
    check("no_wd_count", job_count, 8'd5);
    stub_en = 1'b1;
`endif

    // Reset mid-job, then late done pulses must be ignored.
    go = 1'b1; step(); go = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst_outputs", {busy, core_start, res_valid, timeout_err, res_data, job_count}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) if (ov[i] !== 32'd0) seen = 1'b1;
    check("rst_operands", seen, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      man_done = (i == 4);
      step();
      if (res_valid || busy) seen = 1'b1;
    end
    man_done = 1'b0;
    check("rst_late_done", {seen, job_count}, 9'd0);

    // 256 jobs wrap the counter back to 0.
    for (int j = 0; j < 256; j++) begin
      go = 1'b1; step(); go = 1'b0;
      wait_idle(30, "wrap_idle_timeout");
      if (j == 254) check("wrap_255", job_count, 8'd255);
    end
    check("wrap_0", job_count, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
